// File: rtl/apb2_cmd_master.sv
// Byte-stream to APB2 master bridge: decodes read/write command frames from the
// host link into single APB2 transfers and returns one response byte per frame.
module apb2_cmd_master #(
    parameter int unsigned ADDR_BITS      = 20,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [7:0]           out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ADDR_BITS-1:0] PADDR,
    output logic                 PSEL,
    output logic                 PENABLE,
    output logic                 PWRITE,
    output logic [7:0]           PWDATA,
    input  logic [7:0]           PRDATA
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR0, S_ADDR1, S_ADDR2, S_WDATA,
        S_SETUP, S_ACCESS, S_ERR, S_RESP
    } state_t;

    state_t               r_state;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [7:0]           r_out_data;
    logic [ADDR_BITS-1:0] r_addr;
    logic                 r_is_write;
    logic [ADDR_BITS-1:0] r_paddr;
    logic                 r_psel;
    logic                 r_penable;
    logic                 r_pwrite;
    logic [7:0]           r_pwdata;
    logic [CNT_W-1:0]     r_cnt;

    logic                 w_in_fire;
    logic                 w_out_fire;
    logic                 w_in_frame;
    logic                 w_timeout;
    logic [ADDR_BITS-1:0] w_addr_full;

    assign w_in_fire   = in_valid && r_in_ready;
    assign w_out_fire  = r_out_valid && out_ready;
    assign w_in_frame  = (r_state == S_ADDR0) || (r_state == S_ADDR1) ||
                         (r_state == S_ADDR2) || (r_state == S_WDATA);
    // Timeout fires on the edge where the stall count would reach TIMEOUT_CYCLES.
    assign w_timeout   = (TIMEOUT_CYCLES != 0) && w_in_frame && !w_in_fire &&
                         (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_addr_full = r_addr | ADDR_BITS'({in_data, 16'h0000});

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign PADDR     = r_paddr;
    assign PSEL      = r_psel;
    assign PENABLE   = r_penable;
    assign PWRITE    = r_pwrite;
    assign PWDATA    = r_pwdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'h00;
            r_addr      <= '0;
            r_is_write  <= 1'b0;
            r_paddr     <= '0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= 8'h00;
            r_cnt       <= '0;
        end else begin
            if ((TIMEOUT_CYCLES != 0) && w_in_frame && !w_in_fire && !w_timeout)
                r_cnt <= r_cnt + CNT_W'(1);
            else
                r_cnt <= '0;

            case (r_state)
                S_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (w_in_fire) begin
                        if (in_data == 8'h01 || in_data == 8'h02) begin
                            r_is_write <= (in_data == 8'h01);
                            r_state    <= S_ADDR0;
                        end else begin
                            r_out_data <= 8'hFF;
                            r_in_ready <= 1'b0;
                            r_state    <= S_ERR;
                        end
                    end
                end
                S_ADDR0: begin
                    if (w_in_fire) begin
                        r_addr  <= ADDR_BITS'(in_data);
                        r_state <= S_ADDR1;
                    end else if (w_timeout) begin
                        r_state <= S_IDLE;
                    end
                end
                S_ADDR1: begin
                    if (w_in_fire) begin
                        r_addr  <= r_addr | ADDR_BITS'({in_data, 8'h00});
                        r_state <= S_ADDR2;
                    end else if (w_timeout) begin
                        r_state <= S_IDLE;
                    end
                end
                S_ADDR2: begin
                    if (w_in_fire) begin
                        if (r_is_write) begin
                            r_addr  <= w_addr_full;
                            r_state <= S_WDATA;
                        end else begin
                            r_paddr    <= w_addr_full;
                            r_pwrite   <= 1'b0;
                            r_psel     <= 1'b1;
                            r_in_ready <= 1'b0;
                            r_state    <= S_SETUP;
                        end
                    end else if (w_timeout) begin
                        r_state <= S_IDLE;
                    end
                end
                S_WDATA: begin
                    if (w_in_fire) begin
                        r_paddr    <= r_addr;
                        r_pwdata   <= in_data;
                        r_pwrite   <= 1'b1;
                        r_psel     <= 1'b1;
                        r_in_ready <= 1'b0;
                        r_state    <= S_SETUP;
                    end else if (w_timeout) begin
                        r_state <= S_IDLE;
                    end
                end
                S_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= S_ACCESS;
                end
                S_ACCESS: begin
                    r_psel      <= 1'b0;
                    r_penable   <= 1'b0;
                    r_out_data  <= r_pwrite ? 8'h00 : PRDATA;
                    r_out_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_ERR: begin
                    r_out_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (w_out_fire) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_psel      <= 1'b0;
                    r_penable   <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb2_cmd_master.sv
// Directed bench for apb2_cmd_master: write/read frames, bad opcode, timeout,
// response backpressure and reset during an APB access.
module tb_apb2_cmd_master;

    logic        clk;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [7:0]  PWDATA;
    logic [7:0]  PRDATA;

    int total = 0;
    int bad   = 0;
    int psel_cnt = 0;

    apb2_cmd_master #(.ADDR_BITS(20), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PRDATA(PRDATA)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count cycles with PSEL high, sampled mid-cycle.
    always @(negedge clk) if (PSEL === 1'b1) psel_cnt++;

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one byte and return 1ns after the edge at which it transferred.
    task automatic send_byte(input logic [7:0] b);
        int n;
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("in_ready_wait", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send4(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
        send_byte(a); send_byte(b); send_byte(c); send_byte(d);
    endtask

    int base;
    logic stable;

    initial begin
        rst = 1'b0; in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b1; PRDATA = 8'h00;
        tick(); tick();
        check("rst_psel",     32'(PSEL),      32'd0);
        check("rst_penable",  32'(PENABLE),   32'd0);
        check("rst_in_ready", 32'(in_ready),  32'd0);
        check("rst_out_valid",32'(out_valid), 32'd0);
        check("rst_paddr",    32'(PADDR),     32'd0);
        check("rst_pwdata",   32'(PWDATA),    32'd0);
        rst = 1'b1;
        tick();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Write 0x5A to 0x01234
        base = psel_cnt;
        send4(8'h01, 8'h34, 8'h12, 8'h00); send_byte(8'h5A);
        check("wr_setup_psel",    32'(PSEL),    32'd1);
        check("wr_setup_penable", 32'(PENABLE), 32'd0);
        check("wr_paddr",         32'(PADDR),   32'h01234);
        check("wr_pwrite",        32'(PWRITE),  32'd1);
        check("wr_pwdata",        32'(PWDATA),  32'h5A);
        check("wr_in_ready",      32'(in_ready),32'd0);
        tick();
        check("wr_access", {30'd0, PSEL, PENABLE}, 32'd3);
        tick();
        check("wr_resp_valid", 32'(out_valid), 32'd1);
        check("wr_resp_data",  32'(out_data),  32'h00);
        check("wr_resp_psel",  32'(PSEL),      32'd0);
        check("wr_hold_paddr", 32'(PADDR),     32'h01234);
        tick();
        check("wr_done_valid", 32'(out_valid), 32'd0);
        check("wr_done_ready", 32'(in_ready),  32'd1);
        check("wr_psel_cycles", 32'(psel_cnt - base), 32'd2);

        // Read from 0x00000, slave returns 0x03
        PRDATA = 8'h03;
        send4(8'h02, 8'h00, 8'h00, 8'h00);
        check("rd_paddr",  32'(PADDR),  32'h00000);
        check("rd_pwrite", 32'(PWRITE), 32'd0);
        tick(); tick();
        check("rd_resp_valid", 32'(out_valid), 32'd1);
        check("rd_resp_data",  32'(out_data),  32'h03);
        tick();

        // Invalid opcode, then a normal read at 0x01000
        base = psel_cnt;
        send_byte(8'h7E);
        check("bad_early_valid", 32'(out_valid), 32'd0);
        tick();
        check("bad_resp_valid", 32'(out_valid), 32'd1);
        check("bad_resp_data",  32'(out_data),  32'hFF);
        tick();
        check("bad_done_valid", 32'(out_valid), 32'd0);
        check("bad_no_psel",    32'(psel_cnt - base), 32'd0);
        PRDATA = 8'hA5;
        send4(8'h02, 8'h00, 8'h10, 8'h00);
        check("bad_next_paddr", 32'(PADDR), 32'h01000);
        tick(); tick();
        check("bad_next_data", 32'(out_data), 32'hA5);
        tick();

        // Stall of 16 cycles drops the partial frame
        base = psel_cnt;
        send_byte(8'h01); send_byte(8'h34);
        repeat (16) tick();
        check("to_no_psel",  32'(psel_cnt - base), 32'd0);
        check("to_no_resp",  32'(out_valid), 32'd0);
        check("to_in_ready", 32'(in_ready),  32'd1);
        PRDATA = 8'h3C;
        send4(8'h02, 8'h78, 8'h56, 8'h00);
        check("to_fresh_pwrite", 32'(PWRITE), 32'd0);
        check("to_fresh_paddr",  32'(PADDR),  32'h05678);
        tick(); tick();
        check("to_fresh_data", 32'(out_data), 32'h3C);
        tick();

        // Stall of 15 cycles keeps the frame alive
        send_byte(8'h01); send_byte(8'h34);
        repeat (15) tick();
        send_byte(8'h12); send_byte(8'h00); send_byte(8'h77);
        check("st15_psel",   32'(PSEL),   32'd1);
        check("st15_paddr",  32'(PADDR),  32'h01234);
        check("st15_pwdata", 32'(PWDATA), 32'h77);
        tick(); tick();
        check("st15_resp", {23'd0, out_valid, out_data}, 32'h100);
        tick();

        // Response backpressure for 20 cycles
        out_ready = 1'b0;
        PRDATA = 8'h96;
        send4(8'h02, 8'h56, 8'h34, 8'h12);
        check("bp_paddr", 32'(PADDR), 32'h23456);
        tick(); tick();
        PRDATA = 8'h00;
        in_data = 8'h01; in_valid = 1'b1;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (out_valid !== 1'b1 || out_data !== 8'h96 || in_ready !== 1'b0) stable = 1'b0;
            tick();
        end
        check("bp_stable", 32'(stable), 32'd1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_done_valid", 32'(out_valid), 32'd0);
        check("bp_done_ready", 32'(in_ready),  32'd1);
        PRDATA = 8'h5C;
        send4(8'h02, 8'h01, 8'h00, 8'h00);
        check("bp_next_pwrite", 32'(PWRITE), 32'd0);
        check("bp_next_paddr",  32'(PADDR),  32'h00001);
        tick(); tick();
        check("bp_next_data", 32'(out_data), 32'h5C);
        tick();

        // Reset during ACCESS of a write
        send4(8'h01, 8'h00, 8'h00, 8'h00); send_byte(8'h11);
        tick();
        check("rs_in_access", 32'(PENABLE), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("rs_psel",    32'(PSEL),      32'd0);
        check("rs_penable", 32'(PENABLE),   32'd0);
        check("rs_valid",   32'(out_valid), 32'd0);
        tick(); tick();
        rst = 1'b1;
        check("rs_paddr",    32'(PADDR),    32'd0);
        check("rs_pwrite",   32'(PWRITE),   32'd0);
        check("rs_in_ready", 32'(in_ready), 32'd0);
        tick();
        send4(8'h01, 8'hCD, 8'hAB, 8'h0F); send_byte(8'h42);
        check("rs_wr_paddr",  32'(PADDR),  32'hFABCD);
        check("rs_wr_pwdata", 32'(PWDATA), 32'h42);
        tick(); tick();
        check("rs_wr_resp", {23'd0, out_valid, out_data}, 32'h100);
        tick();
        check("rs_wr_done", 32'(in_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb2_cmd_master.md
# apb2_cmd_master

Byte-stream to APB2 master bridge for the tester FPGA. Turns framed read/write commands, arriving as bytes from the host control link (SPI/UART front end), into single APB2 transfers on the peripherals bus (20-bit PADDR, 8-bit data, no PREADY). It returns one response byte per command. It is the initiator that drives the peripheral register bus, the config/GPIO/SPI/UART/I2C/IO-metrics slaves, through the existing slave mux.

## Interface
- ADDR_BITS, 20: APB address width (1..24); frame address bits above this are ignored.
- TIMEOUT_CYCLES, 1000: idle cycles allowed between bytes of one frame before the frame is discarded; 0 disables the timeout.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- in_data  in  8  command byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  bridge accepts a byte this cycle; a byte transfers on in_valid && in_ready.
- out_data  out  8  response byte.
- out_valid  out  1  response pending; held until accepted.
- out_ready  in  1  sink accepts the response; it transfers on out_valid && out_ready.
- PADDR  out  ADDR_BITS  APB address.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB access phase.
- PWRITE  out  1  1 = write, 0 = read.
- PWDATA  out  8  APB write data.
- PRDATA  in  8  APB read data (from slave mux).

## Operation
- Frame format, bytes in order:
  - opcode: 0x01 = write, 0x02 = read.
  - ADDR[7:0], ADDR[15:8], ADDR[23:16].
  - write only: DATA.
- FSM states and transitions:
  - IDLE: accept opcode. 0x01/0x02 -> ADDR0. Any other opcode -> RESP with out_data=0xFF and no APB transfer.
  - ADDR0 -> ADDR1 -> ADDR2: one accepted byte per state, stored into the address register.
  - ADDR2 -> WDATA if write, -> SETUP if read.
  - WDATA: accept the data byte -> SETUP.
  - SETUP: PSEL=1, PENABLE=0 -> ACCESS.
  - ACCESS: PSEL=1, PENABLE=1. On read, capture PRDATA into out_data at the end of this cycle; on write, out_data=0x00. -> RESP.
  - RESP: out_valid=1; on out_ready -> IDLE.
- in_ready=1 only in IDLE, ADDR0..2 and WDATA; 0 in SETUP, ACCESS, RESP and during reset.
- PADDR, PWRITE and PWDATA are registered and stable from SETUP through ACCESS. After the transfer they hold their last values while PSEL=0 and PENABLE=0.
- PADDR = received 24-bit address [ADDR_BITS-1:0].
- Timeout:
  - A counter runs while in ADDR0..WDATA and clears on every accepted byte and on entry to IDLE.
  - When it reaches TIMEOUT_CYCLES without an accepted byte, the FSM returns to IDLE on the next edge. The partial frame is dropped, with no APB transfer and no response.
  - The counter is inactive in IDLE, SETUP, ACCESS and RESP.
- Exactly one APB transfer per valid frame. PSEL never asserts outside SETUP/ACCESS.

## Timing
- Reset (rst=0, asynchronous): state IDLE; PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, out_valid=0, out_data=0, in_ready=0, counters cleared.
- First edge after rst release: in_ready=1.
- Last frame byte accepted at edge N:
  - SETUP during cycle N..N+1.
  - ACCESS during N+1..N+2.
  - out_valid=1 from edge N+2.
- Read data is PRDATA sampled at the edge ending ACCESS. Slaves register read data during SETUP, so it is valid in ACCESS.
- Response accepted at edge M: IDLE and in_ready=1 from edge M. A new opcode can be accepted at edge M+1.
- Minimum frame-to-frame period: write 8 cycles, read 7 cycles, given back-to-back bytes and out_ready=1.
- out_valid held with out_data stable indefinitely while out_ready=0. No input is accepted meanwhile.
- Invalid opcode accepted at edge N: out_valid=1 from edge N+1 with out_data=0xFF.
- Reset asserted mid-transfer (including during ACCESS): PSEL and PENABLE drop immediately (asynchronously). The pending response is lost.

## Test plan
- Write frame 01 34 12 00 5A, out_ready=1 -> one SETUP cycle then one ACCESS cycle with PADDR=0x01234, PWRITE=1, PWDATA=0x5A; response 0x00; PSEL high for exactly 2 cycles.
- Read frame 02 00 00 00 with PRDATA=0x03 during ACCESS -> PADDR=0x00000, PWRITE=0; response 0x03 two cycles after the last byte is accepted.
- Opcode 0x7E -> response 0xFF; PSEL stays 0; the next frame 02 00 10 00 performs a normal read at 0x01000.
- TIMEOUT_CYCLES=16, send 01 34 then stall 16 cycles -> FSM in IDLE; no PSEL, no response; the following byte 02 is treated as a fresh opcode. A stall of 15 cycles instead -> the frame completes normally.
- Read with out_ready=0 for 20 cycles -> out_valid and out_data stable, in_ready=0, and bytes offered meanwhile are not consumed; releasing out_ready -> handshake, then in_ready=1.
- Assert rst during ACCESS of a write -> PSEL=0 and PENABLE=0 immediately, out_valid=0; after release, a write frame completes normally with all outputs at their reset values beforehand.
